interlaken_rpt_seq: RTL and testbench
=====================================

Name: interlaken_rpt_seq

Overview:
- Repeater-end control sequencer for the Interlaken latency link; it is the responder counterpart of the driver-side bring-up/packet FSM.
- Runs on the repeater FPGA:
  - brings up the local exdes core;
  - answers the driver's post-alignment handshake;
  - echoes NUM_ROUNDS packet rounds, restarting the LBUS generators between rounds;
  - reports done, fail or timeout.
- Sits between the repeater interlaken_0_exdes instance (status LEDs and restart input) and board-level status.

Parameters:
- NUM_ROUNDS, 2: packet rounds to echo before DONE. Range 1..255.
- TIMEOUT_CYCLES, 1048575: max init_clk cycles allowed in any guarded wait state. Range 2..2^20-1; counter is 20 bits.
- RESET_CYCLES, 4: cycles sys_reset is held high after reset release. Range 1..15.

Ports:
- init_clk  in  1  sole clock.
- clk_reset_n  in  1  asynchronous, active-low reset.
- rx_gt_locked_led  in  1  exdes GT lock (level).
- rx_aligned_led  in  1  exdes RX alignment (level).
- hs_req_in  in  1  single-cycle pulse: driver hello word decoded on RX.
- hs_ack_out  out  1  single-cycle pulse: request the TX path to send the ack word.
- rx_done_led  in  1  RX round complete (level).
- rx_busy_led  in  1  RX checker busy (level).
- rx_failed_led  in  1  RX checker failure (level).
- tx_done_led  in  1  TX round complete (level).
- tx_busy_led  in  1  TX generator busy (level).
- sys_reset  out  1  active-high reset to exdes.
- lbus_tx_rx_restart_in  out  1  single-cycle restart pulse to exdes.
- present_state  out  4  current FSM state encoding.
- round_cnt  out  8  completed rounds.
- done  out  1  sticky; set in DONE.
- timed_out  out  1  sticky; set by a timeout.
- rx_failed_flag  out  1  sticky; set by an RX failure.
- latency_cycles  out  32  see Optional Feature.

Behaviour:
- Reset values (async on clk_reset_n=0):
  - present_state=GT_LOCK_WAIT(0), sys_reset=1, sys_reset counter=0.
  - hs_ack_out=0, lbus_tx_rx_restart_in=0, round_cnt=0.
  - done=0, timed_out=0, rx_failed_flag=0, timeout counter=0, latency_cycles=0.
- sys_reset after reset release:
  - stays 1 for exactly RESET_CYCLES rising edges, then 0 until the next reset;
  - the FSM holds in GT_LOCK_WAIT while sys_reset=1.
- State encodings and transitions (all registered, one transition per cycle):
  - 0 GT_LOCK_WAIT: rx_gt_locked_led=1 -> 1.
  - 1 RX_ALIGN_WAIT: rx_aligned_led=1 -> 2.
  - 2 HS_WAIT: hs_req_in=1 -> 3. A hs_req_in pulse seen in any other state is ignored.
  - 3 HS_ACK: hs_ack_out=1 for this one cycle -> 4.
  - 4 ECHO_RX: rx_failed_led=1 -> 11 and set rx_failed_flag; else rx_done_led=1 -> 5. Failure has priority if both are high.
  - 5 ECHO_TX: tx_done_led=1 -> round_cnt+1.
    - If the new count equals NUM_ROUNDS -> 9.
    - Otherwise -> 6.
  - 6 RESTART_WAIT: tx_busy_led=0 and rx_busy_led=0 -> 7.
  - 7 RESTART: lbus_tx_rx_restart_in=1 for exactly one cycle -> 8.
  - 8 BUSY_WAIT: tx_busy_led=1 and rx_busy_led=1 -> 4.
  - 9 DONE_WAIT: both busy LEDs low -> 10.
  - 10 DONE: terminal; done=1.
  - 11 FAIL: terminal; exit only by reset.
- Timeout:
  - 20-bit counter, cleared on every state change.
  - Increments each cycle in states 2, 4, 5, 6, 8 and 9.
  - When count = TIMEOUT_CYCLES-1 and the exit condition is not met that cycle: -> FAIL, set timed_out.
  - An exit condition in the same cycle wins over the timeout.
- Alignment loss:
  - rx_aligned_led=0 in any state 2..9 -> RX_ALIGN_WAIT.
  - round_cnt cleared; pending pulses suppressed; sticky flags kept.
  - Alignment loss has priority over every other transition except reset.
- Pulses:
  - hs_ack_out and lbus_tx_rx_restart_in are never high for 2 consecutive cycles.
  - Each is asserted only in its own state.
- round_cnt saturates at NUM_ROUNDS and never wraps.

Optional Feature:
- Macro: INTERLAKEN_RPT_LATENCY_EN.
- Enabled:
  - 32-bit cycle counter clears and starts on entry to ECHO_RX.
  - It stops on the cycle rx_done_led is first seen in ECHO_RX; that value is latched into latency_cycles.
  - The counter saturates at 0xFFFFFFFF.
  - latency_cycles holds the last completed round's value; reset clears it to 0.
- Disabled:
  - latency_cycles is tied to 0 and no counter logic is present.
  - All other behaviour is identical.

Test Plan:
- Nominal bring-up, NUM_ROUNDS=2: raise lock, then align, pulse hs_req_in, then toggle rx_done/tx_done and the busy LEDs per round.
  - hs_ack_out pulses once, 1 cycle after HS_WAIT sees the request.
  - Exactly one restart pulse occurs between rounds.
  - round_cnt=2, done=1, present_state=10.
- Reset release: clk_reset_n low then high, with lock already high.
  - sys_reset=1 for 4 edges.
  - The FSM leaves state 0 on the first cycle after sys_reset falls.
- Timeout, TIMEOUT_CYCLES=16: align, never pulse hs_req_in.
  - FAIL entered exactly 16 cycles after entering HS_WAIT; timed_out=1; no hs_ack_out.
- RX failure: in ECHO_RX, assert rx_failed_led and rx_done_led in the same cycle.
  - -> FAIL with rx_failed_flag=1, timed_out=0, round_cnt unchanged.
- Alignment drop: in BUSY_WAIT with round_cnt=1, drop rx_aligned_led for 1 cycle.
  - -> RX_ALIGN_WAIT, round_cnt=0, no restart pulse.
  - Re-align and re-handshake, then 2 rounds complete normally.
- With INTERLAKEN_RPT_LATENCY_EN: assert rx_done_led 37 cycles after ECHO_RX entry -> latency_cycles=37.
- Without INTERLAKEN_RPT_LATENCY_EN: the same stimulus leaves latency_cycles=0.

Source files
------------

// File: rtl/interlaken_rpt_seq_if.sv
// Interlaken repeater sequencer bundle.
// Carries the exdes status LEDs, the handshake strobes, the exdes reset and
// restart controls, and the board-level status outputs of the sequencer.
//   master : sequencer side (consumes LEDs/hs_req_in, drives control + status)
//   slave  : exdes / board side
interface interlaken_rpt_seq_if;
  logic        rx_gt_locked_led;
  logic        rx_aligned_led;
  logic        hs_req_in;
  logic        hs_ack_out;
  logic        rx_done_led;
  logic        rx_busy_led;
  logic        rx_failed_led;
  logic        tx_done_led;
  logic        tx_busy_led;
  logic        sys_reset;
  logic        lbus_tx_rx_restart_in;
  logic [3:0]  present_state;
  logic [7:0]  round_cnt;
  logic        done;
  logic        timed_out;
  logic        rx_failed_flag;
  logic [31:0] latency_cycles;

  modport master (
    input  rx_gt_locked_led, rx_aligned_led, hs_req_in, rx_done_led,
           rx_busy_led, rx_failed_led, tx_done_led, tx_busy_led,
    output hs_ack_out, sys_reset, lbus_tx_rx_restart_in, present_state,
           round_cnt, done, timed_out, rx_failed_flag, latency_cycles
  );

  modport slave (
    output rx_gt_locked_led, rx_aligned_led, hs_req_in, rx_done_led,
           rx_busy_led, rx_failed_led, tx_done_led, tx_busy_led,
    input  hs_ack_out, sys_reset, lbus_tx_rx_restart_in, present_state,
           round_cnt, done, timed_out, rx_failed_flag, latency_cycles
  );
endinterface

// File: rtl/interlaken_rpt_seq.sv
// Interlaken repeater-end control sequencer.
// Brings up the local exdes core (sys_reset hold, GT lock, RX alignment),
// answers the driver's hello with a one-cycle ack strobe, echoes NUM_ROUNDS
// packet rounds with a one-cycle LBUS restart between rounds, and reports
// done / RX failure / timeout as sticky flags.
// Ports:
//   init_clk     - sole clock
//   clk_reset_n  - asynchronous active-low reset
//   bus          - interlaken_rpt_seq_if.master (LED inputs, hs_req_in,
//                  hs_ack_out, sys_reset, lbus_tx_rx_restart_in, status)
// Optional feature: define INTERLAKEN_RPT_LATENCY_EN to measure ECHO_RX
// entry-to-rx_done latency into latency_cycles (otherwise tied to 0).
module interlaken_rpt_seq #(
  parameter int NUM_ROUNDS     = 2,
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int RESET_CYCLES   = 4
) (
  input  logic                  init_clk,
  input  logic                  clk_reset_n,
  interlaken_rpt_seq_if.master  bus
);

  typedef enum logic [3:0] {
    GT_LOCK_WAIT  = 4'd0,
    RX_ALIGN_WAIT = 4'd1,
    HS_WAIT       = 4'd2,
    HS_ACK        = 4'd3,
    ECHO_RX       = 4'd4,
    ECHO_TX       = 4'd5,
    RESTART_WAIT  = 4'd6,
    RESTART       = 4'd7,
    BUSY_WAIT     = 4'd8,
    DONE_WAIT     = 4'd9,
    DONE          = 4'd10,
    FAIL          = 4'd11
  } state_t;

  state_t      state_q;
  logic [3:0]  rst_cnt_q;
  logic        sys_reset_q;
  logic [19:0] to_cnt_q;
  logic [7:0]  round_q;
  logic [7:0]  round_d;
  logic        ack_q, restart_q, done_q, timed_out_q, rx_failed_q;

  logic        guarded, exit_c, align_lost, to_hit, links_idle, links_busy;

  assign links_idle = !bus.tx_busy_led && !bus.rx_busy_led;
  assign links_busy =  bus.tx_busy_led &&  bus.rx_busy_led;
  // round_cnt never wraps past NUM_ROUNDS
  assign round_d    = (round_q == 8'(NUM_ROUNDS)) ? round_q : round_q + 8'd1;

  // Exit condition of each timeout-guarded wait state; an exit in the same
  // cycle as the last allowed count wins over the timeout.
  always_comb begin
    guarded = 1'b0;
    exit_c  = 1'b0;
    case (state_q)
      HS_WAIT:      begin guarded = 1'b1; exit_c = bus.hs_req_in;                       end
      ECHO_RX:      begin guarded = 1'b1; exit_c = bus.rx_failed_led || bus.rx_done_led; end
      ECHO_TX:      begin guarded = 1'b1; exit_c = bus.tx_done_led;                     end
      RESTART_WAIT: begin guarded = 1'b1; exit_c = links_idle;                          end
      BUSY_WAIT:    begin guarded = 1'b1; exit_c = links_busy;                          end
      DONE_WAIT:    begin guarded = 1'b1; exit_c = links_idle;                          end
      default:      ;
    endcase
  end

  assign align_lost = (state_q >= HS_WAIT) && (state_q <= DONE_WAIT) && !bus.rx_aligned_led;
  assign to_hit     = guarded && !exit_c && (to_cnt_q == 20'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      state_q     <= GT_LOCK_WAIT;
      rst_cnt_q   <= '0;
      sys_reset_q <= 1'b1;
      to_cnt_q    <= '0;
      round_q     <= '0;
      ack_q       <= 1'b0;
      restart_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      rx_failed_q <= 1'b0;
    end else begin
      ack_q     <= 1'b0;
      restart_q <= 1'b0;

      if (sys_reset_q) begin
        rst_cnt_q <= rst_cnt_q + 4'd1;
        if (rst_cnt_q == 4'(RESET_CYCLES - 1)) sys_reset_q <= 1'b0;
      end

      // Counts only while parked in a guarded state; any state change clears it.
      to_cnt_q <= (guarded && !exit_c && !align_lost && !to_hit) ? to_cnt_q + 20'd1 : '0;

      if (align_lost) begin
        state_q <= RX_ALIGN_WAIT;
        round_q <= '0;
      end else if (to_hit) begin
        state_q     <= FAIL;
        timed_out_q <= 1'b1;
      end else begin
        case (state_q)
          GT_LOCK_WAIT:  if (!sys_reset_q && bus.rx_gt_locked_led) state_q <= RX_ALIGN_WAIT;
          RX_ALIGN_WAIT: if (bus.rx_aligned_led) state_q <= HS_WAIT;
          HS_WAIT:       if (bus.hs_req_in) begin
                           state_q <= HS_ACK;
                           ack_q   <= 1'b1;
                         end
          HS_ACK:        state_q <= ECHO_RX;
          ECHO_RX:       if (bus.rx_failed_led) begin
                           state_q     <= FAIL;
                           rx_failed_q <= 1'b1;
                         end else if (bus.rx_done_led) begin
                           state_q <= ECHO_TX;
                         end
          ECHO_TX:       if (bus.tx_done_led) begin
                           round_q <= round_d;
                           state_q <= (round_d == 8'(NUM_ROUNDS)) ? DONE_WAIT : RESTART_WAIT;
                         end
          RESTART_WAIT:  if (links_idle) begin
                           state_q   <= RESTART;
                           restart_q <= 1'b1;
                         end
          RESTART:       state_q <= BUSY_WAIT;
          BUSY_WAIT:     if (links_busy) state_q <= ECHO_RX;
          DONE_WAIT:     if (links_idle) begin
                           state_q <= DONE;
                           done_q  <= 1'b1;
                         end
          default:       ;  // DONE and FAIL are terminal
        endcase
      end
    end
  end

`ifdef INTERLAKEN_RPT_LATENCY_EN
  logic [31:0] lat_cnt_q, lat_q;

  // lat_cnt_q is zero in the first ECHO_RX cycle, so a done seen in that
  // cycle measures 1.
  always_ff @(posedge init_clk or negedge clk_reset_n) begin
    if (!clk_reset_n) begin
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      if (state_q != ECHO_RX)    lat_cnt_q <= '0;
      else if (lat_cnt_q != '1)  lat_cnt_q <= lat_cnt_q + 32'd1;
      if (state_q == ECHO_RX && !align_lost && !bus.rx_failed_led && bus.rx_done_led)
        lat_q <= (lat_cnt_q == '1) ? '1 : lat_cnt_q + 32'd1;
    end
  end

  assign bus.latency_cycles = lat_q;
`else
  assign bus.latency_cycles = '0;
`endif

  assign bus.present_state         = state_q;
  assign bus.sys_reset             = sys_reset_q;
  assign bus.hs_ack_out            = ack_q;
  assign bus.lbus_tx_rx_restart_in = restart_q;
  assign bus.round_cnt             = round_q;
  assign bus.done                  = done_q;
  assign bus.timed_out             = timed_out_q;
  assign bus.rx_failed_flag        = rx_failed_q;

endmodule

// File: tb/tb_interlaken_rpt_seq.sv
module tb_interlaken_rpt_seq;
  localparam int NR = 2;
  localparam int TO = 40;
  localparam int RC = 4;
`ifdef INTERLAKEN_RPT_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  interlaken_rpt_seq_if bus();

  interlaken_rpt_seq #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC)) dut (
    .init_clk(clk), .clk_reset_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int rp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Time-stamp based: a state's age is (now - entry cycle); the timeout and
  // the latency both fall out of that age.
  int          m_st, m_round, m_nrel, m_cyc, m_entry;
  bit          m_sys, m_ack, m_rp, m_done, m_to, m_rf;
  int unsigned m_lat;

  task automatic model_reset();
    m_st = 0; m_round = 0; m_nrel = 0; m_cyc = 0; m_entry = 0;
    m_sys = 1; m_ack = 0; m_rp = 0; m_done = 0; m_to = 0; m_rf = 0; m_lat = 0;
  endtask

  task automatic model_step();
    int nx;
    bit sys_before, idle, both;
    sys_before = m_sys;
    idle = !bus.rx_busy_led && !bus.tx_busy_led;
    both =  bus.rx_busy_led &&  bus.tx_busy_led;
    m_cyc++;
    if (m_nrel < 1000) m_nrel++;
    nx = m_st;
    if (m_st >= 2 && m_st <= 9 && !bus.rx_aligned_led) begin
      nx = 1;
      m_round = 0;
    end else begin
      case (m_st)
        0: if (!sys_before && bus.rx_gt_locked_led) nx = 1;
        1: if (bus.rx_aligned_led) nx = 2;
        2: if (bus.hs_req_in) nx = 3;
        3: nx = 4;
        4: if (bus.rx_failed_led) begin nx = 11; m_rf = 1; end
           else if (bus.rx_done_led) begin nx = 5; m_lat = m_cyc - m_entry; end
        5: if (bus.tx_done_led) begin
             m_round = (m_round < NR) ? m_round + 1 : NR;
             nx = (m_round == NR) ? 9 : 6;
           end
        6: if (idle) nx = 7;
        7: nx = 8;
        8: if (both) nx = 4;
        9: if (idle) nx = 10;
        default: ;
      endcase
      if (nx == m_st && (m_st == 2 || m_st == 4 || m_st == 5 || m_st == 6 || m_st == 8 || m_st == 9)
          && (m_cyc - m_entry) == TO) begin
        nx = 11;
        m_to = 1;
      end
    end
    m_ack = (nx == 3);
    m_rp  = (nx == 7);
    if (nx == 10) m_done = 1;
    m_sys = (m_nrel < RC);
    if (nx != m_st) m_entry = m_cyc;
    m_st = nx;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every-cycle comparison against the model, plus pulse monitors.
  always @(negedge clk) begin
    chk("present_state", bus.present_state, m_st);
    chk("sys_reset", bus.sys_reset, m_sys);
    chk("hs_ack_out", bus.hs_ack_out, m_ack);
    chk("restart", bus.lbus_tx_rx_restart_in, m_rp);
    chk("round_cnt", bus.round_cnt, m_round);
    chk("done", bus.done, m_done);
    chk("timed_out", bus.timed_out, m_to);
    chk("rx_failed_flag", bus.rx_failed_flag, m_rf);
    chk("latency_cycles", bus.latency_cycles, LAT_EN ? m_lat : 0);
    if (bus.hs_ack_out === 1'b1) ack_cnt++;
    if (bus.lbus_tx_rx_restart_in === 1'b1) rp_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic cyc_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    bus.rx_gt_locked_led = 0; bus.rx_aligned_led = 0; bus.hs_req_in = 0;
    bus.rx_done_led = 0; bus.rx_busy_led = 0; bus.rx_failed_led = 0;
    bus.tx_done_led = 0; bus.tx_busy_led = 0;
  endtask

  task automatic wait_st(input int s, input string nm);
    int k;
    k = 0;
    while (int'(bus.present_state) != s && k < 300) begin tick(); k++; end
    chk({"reach_", nm}, bus.present_state, s);
  endtask

  task automatic bringup();
    idle_inputs();
    rst_n = 0;
    cyc_n(2);
    bus.rx_gt_locked_led = 1;
    rst_n = 1;
    cyc_n($urandom_range(4, 8));
    bus.rx_aligned_led = 1;
    bus.rx_busy_led = 1;
    bus.tx_busy_led = 1;
  endtask

  task automatic handshake();
    wait_st(2, "hs_wait");
    cyc_n($urandom_range(0, 3));
    bus.hs_req_in = 1; tick(); bus.hs_req_in = 0;
    chk("hs_ack_pulse", bus.hs_ack_out, 1);
    tick();
    chk("hs_ack_single", bus.hs_ack_out, 0);
  endtask

  task automatic do_round(input int lat, input bit last, input bit chk_lat);
    wait_st(4, "echo_rx");
    bus.rx_busy_led = 1; bus.tx_busy_led = 1;
    cyc_n(lat - 1);
    bus.rx_done_led = 1; tick(); bus.rx_done_led = 0;
    if (chk_lat) chk("latency_hand", bus.latency_cycles, LAT_EN ? lat : 0);
    cyc_n($urandom_range(0, 4));
    bus.tx_done_led = 1; tick(); bus.tx_done_led = 0;
    cyc_n($urandom_range(0, 4));
    bus.rx_busy_led = 0; bus.tx_busy_led = 0;
    if (!last) begin
      wait_st(8, "busy_wait");
      cyc_n($urandom_range(0, 4));
      bus.rx_busy_led = 1; bus.tx_busy_led = 1;
    end
  endtask

  initial begin
    int a0, r0, k;
    idle_inputs();
    #1 rst_n = 0;

    // Reset values and sys_reset release timing (lock already high).
    bus.rx_gt_locked_led = 1;
    tick(); tick();
    chk("rst_state", bus.present_state, 0);
    chk("rst_sys_reset", bus.sys_reset, 1);
    chk("rst_round", bus.round_cnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_latency", bus.latency_cycles, 0);
    rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("rel_sys_reset_e%0d", i), bus.sys_reset, (i < RC) ? 1 : 0);
      chk($sformatf("rel_state_e%0d", i), bus.present_state, (i >= RC + 1) ? 1 : 0);
    end

    // Nominal two-round echo; first round measured at 37 cycles.
    bringup();
    a0 = ack_cnt; r0 = rp_cnt;
    handshake();
    do_round(37, 0, 1);
    do_round($urandom_range(1, 20), 1, 1);
    wait_st(10, "done");
    chk("nom_round_cnt", bus.round_cnt, 2);
    chk("nom_done", bus.done, 1);
    chk("nom_ack_pulses", ack_cnt - a0, 1);
    chk("nom_restart_pulses", rp_cnt - r0, 1);

    // Timeout in HS_WAIT with no request.
    bringup();
    a0 = ack_cnt;
    wait_st(2, "hs_wait_to");
    k = 0;
    while (int'(bus.present_state) != 11 && k < 200) begin tick(); k++; end
    chk("to_cycles", k, TO);
    chk("to_flag", bus.timed_out, 1);
    chk("to_no_ack", ack_cnt - a0, 0);

    // RX failure and done in the same cycle on round 2.
    bringup();
    handshake();
    do_round($urandom_range(1, 10), 0, 0);
    wait_st(4, "echo_rx_fail");
    cyc_n(2);
    bus.rx_failed_led = 1; bus.rx_done_led = 1; tick();
    bus.rx_failed_led = 0; bus.rx_done_led = 0;
    chk("fail_state", bus.present_state, 11);
    chk("fail_flag", bus.rx_failed_flag, 1);
    chk("fail_timed_out", bus.timed_out, 0);
    chk("fail_round", bus.round_cnt, 1);

    // Alignment drop in BUSY_WAIT with one round done, then recovery.
    bringup();
    handshake();
    do_round($urandom_range(1, 10), 1, 0);
    wait_st(8, "busy_wait_drop");
    tick();
    r0 = rp_cnt;
    bus.rx_aligned_led = 0; tick(); bus.rx_aligned_led = 1;
    chk("drop_state", bus.present_state, 1);
    chk("drop_round", bus.round_cnt, 0);
    tick(); tick();
    chk("drop_no_restart", rp_cnt - r0, 0);
    bus.rx_busy_led = 1; bus.tx_busy_led = 1;
    handshake();
    do_round($urandom_range(1, 30), 0, 1);
    do_round($urandom_range(1, 30), 1, 0);
    wait_st(10, "drop_done");
    chk("drop_final_round", bus.round_cnt, 2);
    chk("drop_restarts", rp_cnt - r0, 1);

    // Random soak against the model.
    for (int p = 0; p < 8; p++) begin
      idle_inputs();
      rst_n = 0; tick(); rst_n = 1;
      for (int c = 0; c < 300; c++) begin
        bus.rx_gt_locked_led = ($urandom_range(0, 9) != 0);
        bus.rx_aligned_led   = ($urandom_range(0, 29) != 0);
        bus.hs_req_in        = ($urandom_range(0, 7) == 0);
        bus.rx_done_led      = ($urandom_range(0, 5) == 0);
        bus.rx_failed_led    = ($urandom_range(0, 60) == 0);
        bus.tx_done_led      = ($urandom_range(0, 4) == 0);
        bus.rx_busy_led      = 1'($urandom_range(0, 1));
        bus.tx_busy_led      = 1'($urandom_range(0, 1));
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
